// File: rtl/tri_bus_responder.sv
// Register-file responder on a shared 32-bit tri-state bus with a private core port.
// Read data is driven only in DRIVE, after a turnaround cycle; bus writes beat core writes.

module tri_bus_reg_cell (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_we,
    input  logic [31:0] bus_d,
    input  logic        core_we,
    input  logic [31:0] core_d,
    output logic [31:0] q
);
    // Bus write takes priority when both ports hit this entry on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       q <= '0;
        else if (bus_we)  q <= bus_d;
        else if (core_we) q <= core_d;
    end
endmodule

module tri_bus_responder #(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [31:0]       bus_data,
    input  logic              bus_sel,
    input  logic              bus_wr,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic              bus_ack,
    output logic              bus_err,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_wr_drop,
    output logic              bus_wr_evt,
    output logic [ADDR_W-1:0] bus_wr_addr
);
    typedef enum logic [2:0] {IDLE, WACK, TURN, DRIVE, DONE} state_t;
    typedef struct packed {
        logic              unmapped;
        logic [ADDR_W-1:0] addr;
    } req_t;

    state_t                 state, state_nxt;
    req_t                   req;
    logic [DEPTH-1:0][31:0] regs;
    logic [DEPTH-1:0]       bus_we, core_we;
    logic [31:0]            drive_q;
    logic                   oe;
    logic                   bus_mapped, core_mapped, bus_take_wr, collide;

    assign bus_mapped  = 32'(bus_addr) < 32'(DEPTH);
    assign core_mapped = 32'(core_addr) < 32'(DEPTH);
    assign bus_take_wr = (state == IDLE) && bus_sel && bus_wr && bus_mapped;
    assign collide     = bus_take_wr && core_wr_en && (core_addr == bus_addr);

    // Enable comes only from a flop so the bus is released the instant reset asserts.
    assign bus_data = oe ? drive_q : 'z;

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        assign bus_we[i]  = bus_take_wr && (bus_addr == ADDR_W'(i));
        assign core_we[i] = core_wr_en && (core_addr == ADDR_W'(i));
        tri_bus_reg_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .bus_we  (bus_we[i]),
            .bus_d   (bus_data),
            .core_we (core_we[i]),
            .core_d  (core_wdata),
            .q       (regs[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus_sel) state_nxt = bus_wr ? WACK : TURN;
            WACK:    state_nxt = DONE;
            TURN:    state_nxt = DRIVE;
            DRIVE:   state_nxt = DONE;
            DONE:    if (!bus_sel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered off the next state so they line up with WACK/DRIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req          <= '0;
            oe           <= 1'b0;
            drive_q      <= '0;
            bus_ack      <= 1'b0;
            bus_err      <= 1'b0;
            bus_wr_evt   <= 1'b0;
            bus_wr_addr  <= '0;
            core_rdata   <= '0;
            core_wr_drop <= 1'b0;
        end else begin
            if (state == IDLE && bus_sel) begin
                req.unmapped <= !bus_mapped;
                req.addr     <= bus_addr;
            end
            if (state == TURN) drive_q <= req.unmapped ? '0 : regs[req.addr];
            oe           <= (state_nxt == DRIVE);
            bus_ack      <= (state_nxt == WACK) || (state_nxt == DRIVE);
            bus_err      <= ((state_nxt == WACK) && !bus_mapped) ||
                            ((state_nxt == DRIVE) && req.unmapped);
            bus_wr_evt   <= bus_take_wr;
            if (bus_take_wr) bus_wr_addr <= bus_addr;
            core_wr_drop <= collide;
            core_rdata   <= core_mapped ? regs[core_addr] : '0;
        end
    end
endmodule

// File: doc/tri_bus_responder.md
# tri_bus_responder

Register-file responder for the shared 32-bit tri-state data bus: answers read and write cycles issued by a bus master. It captures write data from the bus and drives read data back onto the bus only during a defined drive window, with a turnaround cycle so the bus never has two drivers. The core side has a private port into the same register file and receives a notification of every bus write.

## Interface
- `ADDR_W`, default 3: bus and core address width.
- `DEPTH`, default 6: implemented registers. Addresses ≥ DEPTH are unmapped. DEPTH ≤ 2^ADDR_W.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `bus_data`, inout, 32: shared tri-state data bus. Driven only in state DRIVE; `'bz` otherwise.
- `bus_sel`, input, 1: master selects this responder. Held until `bus_ack` is seen.
- `bus_wr`, input, 1: 1 = write, 0 = read. Valid with `bus_sel`.
- `bus_addr`, input, ADDR_W: register address. Valid with `bus_sel`.
- `bus_ack`, output, 1: one-cycle completion strobe.
- `bus_err`, output, 1: asserted together with `bus_ack` when the access is unmapped.
- `core_wr_en`, input, 1: core write strobe.
- `core_addr`, input, ADDR_W: core read/write address.
- `core_wdata`, input, 32: core write data.
- `core_rdata`, output, 32: registered read of `core_addr`, one cycle latency.
- `core_wr_drop`, output, 1: one-cycle pulse when a core write loses a collision.
- `bus_wr_evt`, output, 1: one-cycle pulse after a mapped bus write is committed.
- `bus_wr_addr`, output, ADDR_W: address of the last bus write; valid with `bus_wr_evt`.

## Operation
- FSM states: IDLE, WACK, TURN, DRIVE, DONE.
- `bus_sel` is sampled only in IDLE. While in any other state it is ignored.
- IDLE, sel & wr:
  - Mapped address: `regs[addr] <= bus_data` on that same edge.
  - Go to WACK.
- IDLE, sel & !wr: go to TURN. The bus stays undriven (turnaround).
- WACK:
  - `bus_ack`=1; `bus_err`=1 if the address is unmapped.
  - `bus_wr_evt`=1 and `bus_wr_addr` valid, for mapped addresses only.
  - Next state DONE.
- TURN:
  - Load the drive register from `regs[addr]`, using array contents before this edge. Unmapped addresses load 32'h0.
  - Set output enable. Next state DRIVE.
- DRIVE:
  - `bus_data` = drive register, `bus_ack`=1, `bus_err` for unmapped.
  - Output enable clears on the exit edge. Next state DONE.
- DONE: stay while `bus_sel`=1; go to IDLE when `bus_sel`=0. A held `bus_sel` never retriggers a transaction.
- Address, wr and unmapped flag are latched at the IDLE sampling edge. Later changes on the bus inputs have no effect.
- Core write:
  - Commits `regs[core_addr] <= core_wdata` each edge with `core_wr_en`.
  - Collision with a bus write on the same edge to the same address: bus write wins, core write discarded, `core_wr_drop` pulses next cycle.
  - Core writes to unmapped addresses are discarded silently.
- `core_rdata` <= `regs[core_addr]` (pre-edge contents); 0 for unmapped.

## Timing
- Reset, asynchronous and immediate:
  - State IDLE, output enable 0, so `bus_data`='bz at once, even in the middle of DRIVE.
  - All `regs`, the drive register, `core_rdata`, `bus_wr_addr` = 0.
  - `bus_ack`, `bus_err`, `bus_wr_evt`, `core_wr_drop` = 0.
- All outputs are registered. The tri-state enable comes from a flop, never from a bus input.
- Write: sel sampled at edge E0; data captured at E0; `bus_ack` and `bus_wr_evt` high in cycle E0..E1.
- Read: sel sampled at E0; TURN in cycle E0..E1 with bus Z; DRIVE in cycle E1..E2 with data and ack; bus Z again from E2.
- Read latency is 2 cycles from the sampling edge.
- Minimum spacing between transactions is 3 cycles (write) or 4 cycles (read), including DONE.
- A core write at E1 of a read is not visible in that read's data.
- `bus_ack` and `bus_err` are never high outside WACK or DRIVE.

## Test plan
- Reset, then bus write addr 2, data 32'hA5A5_0001 → ack next cycle, err=0, `bus_wr_evt`=1 with `bus_wr_addr`=2; `core_rdata` at addr 2 reads 32'hA5A5_0001.
- Core writes 32'h1234_5678 to addr 5; bus read addr 5 → bus Z in TURN; 32'h1234_5678 with ack in DRIVE; Z afterwards; `bus_data` never X.
- Bus read addr 7 (unmapped, DEPTH=6) → DRIVE data 32'h0, ack=1, err=1; bus write addr 6 → ack=1, err=1, no `bus_wr_evt`, regs unchanged.
- Same edge: bus write 32'hBBBB_0000 and core write 32'hCCCC_0000, both to addr 1 → addr 1 holds 32'hBBBB_0000; `core_wr_drop` pulses once.
- Master holds `bus_sel` 5 cycles after ack → exactly one ack; no new transaction until sel drops for a cycle.
- Assert `rst_n`=0 mid-DRIVE → `bus_data`='bz and ack=0 in the same cycle without waiting for a clock edge; regs read 0 after reset.
